// File: rtl/mips_pc_sequencer.sv
// Next-PC controller for the MIPS fetch stage: sequential, branch, jump, trap vector or hold,
// with post-redirect flush bubbles, fetch handshake and trap entry bookkeeping.
module mips_pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR     = 32'h0000_0000,
  parameter logic [31:0] EXCEPTION_VECTOR = 32'h8000_0180,
  parameter int unsigned FLUSH_CYCLES     = 1
) (
  input  logic        ClockPulse,
  input  logic        ResetN,
  input  logic [31:0] CurrentInstructionAddress,
  input  logic        StallReq,
  input  logic        ImemReady,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        JumpReq,
  input  logic [31:0] JumpTarget,
  input  logic        ExceptionReq,
  output logic [31:0] NextInstructionAddress,
  output logic        FetchValid,
  output logic        FlushIF,
  output logic [31:0] Epc,
  output logic [1:0]  ExcCause,
  output logic [1:0]  State
);

  localparam int unsigned CNT_W = 3;

  localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
  localparam logic [1:0] CAUSE_EXTERNAL   = 2'b10;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    FLUSH = 2'b10,
    TRAP  = 2'b11
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             trap_en;
  logic [1:0]       cause_nxt;
  logic             misaligned;

  // A taken redirect whose target is not word aligned traps instead of redirecting.
  assign misaligned = (JumpReq && (JumpTarget[1:0] != 2'b00)) ||
                      (BranchTaken && (BranchTarget[1:0] != 2'b00));

  assign State = state;

  always_ff @(posedge ClockPulse) begin
    if (!ResetN) begin
      state    <= BOOT;
      cnt      <= '0;
      Epc      <= '0;
      ExcCause <= 2'b00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (trap_en) begin
        Epc      <= CurrentInstructionAddress;
        ExcCause <= cause_nxt;
      end
    end
  end

  always_comb begin
    state_nxt              = state;
    cnt_nxt                = cnt;
    NextInstructionAddress = CurrentInstructionAddress;
    FetchValid             = 1'b0;
    FlushIF                = 1'b0;
    trap_en                = 1'b0;
    cause_nxt              = 2'b00;

    unique case (state)
      BOOT: begin
        NextInstructionAddress = RESET_VECTOR;
        state_nxt              = RUN;
      end
      RUN: begin
        FetchValid = !StallReq;
        if (ExceptionReq || misaligned) begin
          NextInstructionAddress = EXCEPTION_VECTOR;
          FlushIF                = 1'b1;
          trap_en                = 1'b1;
          cause_nxt              = ExceptionReq ? CAUSE_EXTERNAL : CAUSE_MISALIGNED;
          state_nxt              = TRAP;
        end else if (JumpReq || BranchTaken) begin
          NextInstructionAddress = JumpReq ? JumpTarget : BranchTarget;
          FlushIF                = 1'b1;
          if (FLUSH_CYCLES != 0) begin
            state_nxt = FLUSH;
            cnt_nxt   = CNT_W'(FLUSH_CYCLES);
          end
        end else if (StallReq || !ImemReady) begin
          NextInstructionAddress = CurrentInstructionAddress;
        end else begin
          NextInstructionAddress = CurrentInstructionAddress + 32'd4;
        end
      end
      FLUSH: begin
        FlushIF = 1'b1;
        if (ExceptionReq) begin
          NextInstructionAddress = EXCEPTION_VECTOR;
          trap_en                = 1'b1;
          cause_nxt              = CAUSE_EXTERNAL;
          cnt_nxt                = '0;
          state_nxt              = TRAP;
        end else if (cnt <= CNT_W'(1)) begin
          cnt_nxt   = '0;
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      TRAP: begin
        FlushIF   = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = BOOT;
    endcase

    // Reset overrides everything combinationally so the PC register loads the reset vector.
    if (!ResetN) begin
      NextInstructionAddress = RESET_VECTOR;
      FetchValid             = 1'b0;
      FlushIF                = 1'b1;
      trap_en                = 1'b0;
    end
  end

endmodule
